// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MD_BUSY  = 2'd2
  } state_t;

  localparam int MD_CNT_W   = 8;
  localparam int WAIT_CNT_W = 16;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_write;
    logic idex_bubble;
    logic exmem_write;
    logic exmem_bubble;
    logic memwb_bubble;
    logic md_busy;
  } ctrl_t;

  localparam ctrl_t CTRL_DEFAULT = '{
    pc_write:     1'b1,
    ifid_write:   1'b1,
    ifid_flush:   1'b0,
    idex_write:   1'b1,
    idex_bubble:  1'b0,
    exmem_write:  1'b1,
    exmem_bubble: 1'b0,
    memwb_bubble: 1'b0,
    md_busy:      1'b0
  };

  localparam ctrl_t CTRL_RESET = '{default: 1'b0};

  // Whole-pipe freeze while the older instruction in MEM waits on data memory.
  function automatic ctrl_t apply_freeze(input ctrl_t c);
    ctrl_t r;
    r              = c;
    r.pc_write     = 1'b0;
    r.ifid_write   = 1'b0;
    r.idex_write   = 1'b0;
    r.exmem_write  = 1'b0;
    r.memwb_bubble = 1'b1;
    return r;
  endfunction

  function automatic ctrl_t apply_md_stall(input ctrl_t c);
    ctrl_t r;
    r              = c;
    r.pc_write     = 1'b0;
    r.ifid_write   = 1'b0;
    r.idex_write   = 1'b0;
    r.exmem_bubble = 1'b1;
    r.md_busy      = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush sequencer: merges dmem wait, mult/div occupancy,
// taken branch and load-use hazard into pipeline-register controls.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_LATENCY  = 8,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_use_hz,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             md_start,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_bubble,
  output logic             exmem_write,
  output logic             exmem_bubble,
  output logic             memwb_bubble,
  output logic             md_busy,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [MD_CNT_W-1:0]   MD_INIT    = MD_CNT_W'(MD_LATENCY - 1);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(MEM_TIMEOUT);

  state_t                state, state_nxt;
  logic [MD_CNT_W-1:0]   md_cnt, md_cnt_nxt, md_dec;
  logic [WAIT_CNT_W-1:0] wait_cnt, wait_cnt_nxt, wait_inc;
  logic                  mem_hold, md_left, mem_stall, timeout_set;
  ctrl_t                 ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      md_cnt      <= '0;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state    <= state_nxt;
      md_cnt   <= md_cnt_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (timeout_set) begin
        mem_timeout <= 1'b1;
      end
    end
  end

  // md_cnt keeps running through a memory wait so the mult/div stall is never extended.
  always_comb begin
    ctrl         = CTRL_DEFAULT;
    state_nxt    = state;
    md_cnt_nxt   = md_cnt;
    wait_cnt_nxt = wait_cnt;
    mem_stall    = 1'b0;
    mem_hold     = dmem_req && !dmem_ready;
    md_left      = (md_cnt != '0);
    md_dec       = md_left ? (md_cnt - MD_CNT_W'(1)) : md_cnt;
    wait_inc     = (wait_cnt == '1) ? wait_cnt : (wait_cnt + WAIT_CNT_W'(1));

    case (state)
      RUN: begin
        if (mem_hold) begin
          mem_stall    = 1'b1;
          wait_cnt_nxt = WAIT_CNT_W'(1);
          state_nxt    = MEM_WAIT;
        end else if (md_start) begin
          md_cnt_nxt = MD_INIT;
          state_nxt  = MD_BUSY;
        end else if (branch_taken) begin
          ctrl.ifid_flush  = 1'b1;
          ctrl.idex_bubble = 1'b1;
        end else if (load_use_hz) begin
          ctrl.pc_write    = 1'b0;
          ctrl.ifid_write  = 1'b0;
          ctrl.idex_bubble = 1'b1;
        end
      end

      MD_BUSY: begin
        md_cnt_nxt = md_dec;
        if (md_left) begin
          ctrl = apply_md_stall(ctrl);
        end
        if (mem_hold) begin
          mem_stall    = 1'b1;
          wait_cnt_nxt = WAIT_CNT_W'(1);
          state_nxt    = MEM_WAIT;
        end else if (!md_left) begin
          state_nxt = RUN;
        end
      end

      MEM_WAIT: begin
        md_cnt_nxt = md_dec;
        if (md_left) begin
          ctrl = apply_md_stall(ctrl);
        end
        if (dmem_ready) begin
          wait_cnt_nxt = '0;
          state_nxt    = md_left ? MD_BUSY : RUN;
        end else begin
          mem_stall    = 1'b1;
          wait_cnt_nxt = wait_inc;
        end
      end

      default: begin
        state_nxt = RUN;
      end
    endcase

    if (mem_stall) begin
      ctrl = apply_freeze(ctrl);
    end
    timeout_set = mem_stall && (wait_cnt_nxt >= WAIT_LIMIT);

    if (!rst_n) begin
      ctrl = CTRL_RESET;
    end
  end

  assign pc_write     = ctrl.pc_write;
  assign ifid_write   = ctrl.ifid_write;
  assign ifid_flush   = ctrl.ifid_flush;
  assign idex_write   = ctrl.idex_write;
  assign idex_bubble  = ctrl.idex_bubble;
  assign exmem_write  = ctrl.exmem_write;
  assign exmem_bubble = ctrl.exmem_bubble;
  assign memwb_bubble = ctrl.memwb_bubble;
  assign md_busy      = ctrl.md_busy;

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (rst_n && !ctrl.pc_write),
    .clear (1'b0),
    .count (stall_cycles)
  );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed scenarios plus random
// traffic against a cycle-level behavioural model of the stall rules.
module tb_pipe_stall_ctrl;

  localparam int MD_LAT    = 8;
  localparam int MEM_TO    = 4;
  localparam int CW        = 8;
  localparam int STALL_MAX = (1 << CW) - 1;
  localparam logic [8:0] DEF_CTRL = 9'b110101000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load_use_hz = 1'b0, branch_taken = 1'b0, dmem_req = 1'b0;
  logic dmem_ready = 1'b0, md_start = 1'b0;
  logic pc_write, ifid_write, ifid_flush, idex_write, idex_bubble;
  logic exmem_write, exmem_bubble, memwb_bubble, md_busy, mem_timeout;
  logic [CW-1:0] stall_cycles;
  logic [8:0]  obs;
  logic [17:0] obs_all;

  int n_checks = 0;
  int n_fail   = 0;

  // model state: stall cycles owed to mult/div, pending release cycle, wait length
  int   m_md_owed, m_wait_len, m_stalls;
  bit   m_release, m_timeout;
  int   n_md_owed, n_wait_len, n_stalls;
  bit   n_release, n_timeout;
  logic [8:0]  m_exp;
  logic [17:0] m_all;

  pipe_stall_ctrl #(
    .MD_LATENCY (MD_LAT),
    .MEM_TIMEOUT(MEM_TO),
    .CNT_W      (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_use_hz  (load_use_hz),
    .branch_taken (branch_taken),
    .dmem_req     (dmem_req),
    .dmem_ready   (dmem_ready),
    .md_start     (md_start),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .ifid_flush   (ifid_flush),
    .idex_write   (idex_write),
    .idex_bubble  (idex_bubble),
    .exmem_write  (exmem_write),
    .exmem_bubble (exmem_bubble),
    .memwb_bubble (memwb_bubble),
    .md_busy      (md_busy),
    .mem_timeout  (mem_timeout),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  assign obs = {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
                exmem_write, exmem_bubble, memwb_bubble, md_busy};
  assign obs_all = {obs, mem_timeout, stall_cycles};

  function automatic void model_reset();
    m_md_owed  = 0;
    m_wait_len = 0;
    m_stalls   = 0;
    m_release  = 1'b0;
    m_timeout  = 1'b0;
  endfunction

  // Expected outputs for the current inputs, plus the model's next state.
  function automatic void model_eval();
    bit mem_stall, md_occ, free_cyc;
    bit pc, ifw, fl, idw, idb, exw, exb, mwb, busy;
    pc = 1; ifw = 1; fl = 0; idw = 1; idb = 0; exw = 1; exb = 0; mwb = 0; busy = 0;
    mem_stall = (m_wait_len > 0) ? !dmem_ready : (dmem_req && !dmem_ready);
    md_occ    = (m_md_owed > 0);
    free_cyc  = !mem_stall && !md_occ && !m_release;
    n_md_owed = md_occ ? m_md_owed - 1 : 0;
    if (mem_stall) begin
      pc = 0; ifw = 0; idw = 0; exw = 0; mwb = 1;
    end
    if (md_occ) begin
      pc = 0; ifw = 0; idw = 0; exb = 1; busy = 1;
    end
    if (free_cyc) begin
      if (md_start) n_md_owed = MD_LAT - 1;
      else if (branch_taken) begin fl = 1; idb = 1; end
      else if (load_use_hz) begin pc = 0; ifw = 0; idb = 1; end
    end
    n_release  = mem_stall || md_occ;
    n_wait_len = mem_stall ? ((m_wait_len < 65535) ? m_wait_len + 1 : m_wait_len) : 0;
    n_timeout  = m_timeout || (mem_stall && (n_wait_len >= MEM_TO));
    n_stalls   = (!pc && (m_stalls < STALL_MAX)) ? m_stalls + 1 : m_stalls;
    m_exp = {pc, ifw, fl, idw, idb, exw, exb, mwb, busy};
    m_all = {m_exp, m_timeout, m_stalls[CW-1:0]};
  endfunction

  function automatic void model_commit();
    m_md_owed  = n_md_owed;
    m_wait_len = n_wait_len;
    m_stalls   = n_stalls;
    m_release  = n_release;
    m_timeout  = n_timeout;
  endfunction

  // v = {load_use_hz, branch_taken, dmem_req, dmem_ready, md_start}
  task automatic cycle_in(input logic [4:0] v);
    @(negedge clk);
    {load_use_hz, branch_taken, dmem_req, dmem_ready, md_start} = v;
    #1;
    model_eval();
  endtask

  task automatic cycle_end();
    @(posedge clk);
    model_commit();
  endtask

  task automatic do_reset();
    @(negedge clk);
    {load_use_hz, branch_taken, dmem_req, dmem_ready, md_start} = 5'b0;
    rst_n = 1'b0;
    model_reset();
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (obs_all !== 18'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_hold: got %b want %b", obs_all, 18'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cycle_in(5'b00001);
    n_checks++;
    if (obs_all !== {DEF_CTRL, 1'b0, 8'd0}) begin
      n_fail++;
      $display("[TB] FAIL reset_release: got %b want %b", obs_all, {DEF_CTRL, 1'b0, 8'd0});
    end
    cycle_end();
    for (int i = 0; i < 3; i++) begin
      cycle_in(5'b0);
      n_checks++;
      if (obs_all !== m_all) begin
        n_fail++;
        $display("[TB] FAIL reset_md_run c%0d: got %b want %b", i, obs_all, m_all);
      end
      cycle_end();
    end
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (obs_all !== 18'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_md: got %b want %b", obs_all, 18'b0);
    end
    #2 rst_n = 1'b1;
    cycle_in(5'b0);
    n_checks++;
    if (obs_all !== {DEF_CTRL, 1'b0, 8'd0}) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_md_release: got %b want %b", obs_all, {DEF_CTRL, 1'b0, 8'd0});
    end
    cycle_end();
  endtask

  task automatic test_load_use();
    logic [4:0] seq [4] = '{5'b00000, 5'b10000, 5'b00000, 5'b00000};
    int lu_cycles = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle_in(seq[i]);
      if (!pc_write && !ifid_write && idex_bubble) lu_cycles++;
      n_checks++;
      if (obs_all !== m_all) begin
        n_fail++;
        $display("[TB] FAIL load_use c%0d: got %b want %b", i, obs_all, m_all);
      end
      cycle_end();
    end
    #1;
    n_checks++;
    if (lu_cycles != 1 || stall_cycles !== 8'd1) begin
      n_fail++;
      $display("[TB] FAIL load_use_len: got %0d cyc/%0d stalls want 1/1", lu_cycles, stall_cycles);
    end
  endtask

  task automatic test_mem_wait();
    logic [4:0] seq [5] = '{5'b00100, 5'b00100, 5'b00100, 5'b00110, 5'b00000};
    int frz = 0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle_in(seq[i]);
      if (memwb_bubble && !pc_write && !exmem_write) frz++;
      n_checks++;
      if (obs_all !== m_all) begin
        n_fail++;
        $display("[TB] FAIL mem_wait c%0d: got %b want %b", i, obs_all, m_all);
      end
      cycle_end();
    end
    #1;
    n_checks++;
    if (frz != 3 || stall_cycles !== 8'd3 || mem_timeout !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL mem_wait_totals: got frz=%0d stalls=%0d to=%b want 3/3/0",
               frz, stall_cycles, mem_timeout);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 1; i <= 12; i++) begin
      cycle_in((i <= 10) ? 5'b00100 : ((i == 11) ? 5'b00110 : 5'b00000));
      n_checks++;
      if (mem_timeout !== (i >= MEM_TO + 1) || obs_all !== m_all) begin
        n_fail++;
        $display("[TB] FAIL timeout c%0d: got %b want %b (to %b)", i, obs_all, m_all, (i >= MEM_TO + 1));
      end
      cycle_end();
    end
  endtask

  task automatic test_md_busy();
    logic [4:0] seq [10] = '{5'b00001, 5'b00000, 5'b00000, 5'b00100, 5'b00100,
                             5'b00110, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
    int busy_n = 0, exb_n = 0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cycle_in(seq[i]);
      if (md_busy) busy_n++;
      if (exmem_bubble) exb_n++;
      n_checks++;
      if (obs_all !== m_all) begin
        n_fail++;
        $display("[TB] FAIL md_busy c%0d: got %b want %b", i, obs_all, m_all);
      end
      cycle_end();
    end
    #1;
    n_checks++;
    if (busy_n != MD_LAT - 1 || exb_n != MD_LAT - 1 || stall_cycles !== 8'(MD_LAT - 1)) begin
      n_fail++;
      $display("[TB] FAIL md_totals: got busy=%0d exb=%0d stalls=%0d want %0d each",
               busy_n, exb_n, stall_cycles, MD_LAT - 1);
    end
  endtask

  task automatic test_branch_load_use();
    do_reset();
    cycle_in(5'b11000);
    n_checks++;
    if (!(pc_write === 1'b1 && ifid_flush === 1'b1 && idex_bubble === 1'b1) || obs_all !== m_all) begin
      n_fail++;
      $display("[TB] FAIL branch_lu: got %b want %b", obs_all, m_all);
    end
    cycle_end();
    cycle_in(5'b00000);
    n_checks++;
    if (stall_cycles !== 8'd0) begin
      n_fail++;
      $display("[TB] FAIL branch_lu_stalls: got %0d want 0", stall_cycles);
    end
    cycle_end();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      cycle_in(5'b00100);
      cycle_end();
    end
    cycle_in(5'b00110);
    n_checks++;
    if (stall_cycles !== 8'hFF || obs_all !== m_all) begin
      n_fail++;
      $display("[TB] FAIL saturation: got %b want %b", obs_all, m_all);
    end
    cycle_end();
  endtask

  task automatic test_random();
    logic [4:0] v;
    do_reset();
    for (int i = 0; i < 500; i++) begin
      v[4] = ($urandom_range(0, 4) == 0);
      v[3] = ($urandom_range(0, 4) == 0);
      v[2] = (m_wait_len > 0) || ($urandom_range(0, 3) == 0);
      v[1] = ($urandom_range(0, 1) == 1);
      v[0] = ($urandom_range(0, 11) == 0);
      cycle_in(v);
      n_checks++;
      if (obs_all !== m_all) begin
        n_fail++;
        $display("[TB] FAIL random c%0d in=%b: got %b want %b", i, v, obs_all, m_all);
      end
      cycle_end();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load_use();
    test_mem_wait();
    test_timeout();
    test_md_busy();
    test_branch_load_use();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Merges four stall and flush sources into one coherent set of pipeline-register write enables and bubble/flush controls: data-memory wait handshake, multi-cycle mult/div occupancy, load-use hazard indication and EX-stage taken branch.
- Sits between the hazard detection logic, the data-memory interface and the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Keeps a saturating stall-cycle counter and a sticky memory-timeout flag.

Parameters:
MD_LATENCY, 8, cycles the mult/div unit occupies EX after md_start (legal range 2..255)
MEM_TIMEOUT, 64, max consecutive dmem wait cycles before timeout flag sets (legal range 1..65535)
CNT_W, 32, width of stall-cycle counter

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
load_use_hz  in  1  load-use hazard detected in ID (from hazard detection logic)
branch_taken  in  1  branch/jump resolved taken in EX
dmem_req  in  1  MEM stage issuing a data-memory access this cycle
dmem_ready  in  1  data memory completes the access this cycle
md_start  in  1  mult/div instruction entering EX
pc_write  out  1  PC write enable
ifid_write  out  1  IF/ID write enable
ifid_flush  out  1  clear IF/ID to NOP on next edge
idex_write  out  1  ID/EX write enable
idex_bubble  out  1  load NOP into ID/EX (control mux select)
exmem_write  out  1  EX/MEM write enable
exmem_bubble  out  1  load NOP into EX/MEM
memwb_bubble  out  1  load NOP into MEM/WB
md_busy  out  1  mult/div occupancy in progress
mem_timeout  out  1  sticky: a dmem wait exceeded MEM_TIMEOUT
stall_cycles  out  CNT_W  saturating count of cycles with pc_write=0

Behaviour:
- Registered state: FSM state, md_cnt (8b), wait_cnt (16b), mem_timeout, stall_cycles. All control outputs are combinational from state and inputs.
- Reset (rst_n low, asynchronous): state=RUN, md_cnt=0, wait_cnt=0, mem_timeout=0, stall_cycles=0.
  - While rst_n is low, pc_write, ifid_write, idex_write and exmem_write are forced to 0, and all bubble/flush outputs are forced to 0.
- Defaults, absent any condition below: all write enables=1, all bubble/flush outputs=0, md_busy=0.
- States: RUN, MEM_WAIT, MD_BUSY. Condition priority, highest first: memory wait, mult/div, branch, load-use.
- RUN:
  - dmem_req=1 and dmem_ready=0: freeze PC, IF/ID, ID/EX and EX/MEM (write enables=0); memwb_bubble=1; wait_cnt<=1; next state MEM_WAIT.
  - Otherwise md_start=1: md_cnt<=MD_LATENCY-1; next state MD_BUSY. The issuing cycle itself advances normally.
  - Otherwise branch_taken=1: ifid_flush=1 and idex_bubble=1. PC loads the target, so pc_write=1.
  - Otherwise load_use_hz=1: pc_write=0, ifid_write=0, idex_bubble=1. Lasts exactly one cycle per assertion.
  - If branch_taken and load_use_hz are both 1, only the flush applies; the load-use instruction is wrong-path.
- MEM_WAIT:
  - Same freeze pattern as entry.
  - dmem_ready=1: outputs revert to defaults this cycle (the access completes); wait_cnt<=0; next state RUN.
  - Otherwise wait_cnt increments. When wait_cnt reaches MEM_TIMEOUT, mem_timeout<=1; it stays 1 until reset and the wait continues.
  - branch_taken, load_use_hz and md_start are ignored; the sources hold their values because the pipeline is frozen.
- MD_BUSY:
  - md_busy=1; pc_write=ifid_write=idex_write=0; exmem_bubble=1.
  - md_cnt decrements each cycle. In the cycle md_cnt==0, outputs revert to defaults and next state is RUN.
  - Total stalled cycles = MD_LATENCY-1.
  - A dmem_req=1 with dmem_ready=0 from the older instruction in MEM takes priority: next state MEM_WAIT and md_cnt keeps decrementing.
  - If md_cnt reaches 0 while in MEM_WAIT, exit MEM_WAIT to RUN.
  - If md_cnt is still nonzero on exit from MEM_WAIT, return to MD_BUSY.
- stall_cycles: increments in every cycle with rst_n=1 and pc_write=0; saturates at all-ones.
- No combinational path from any output back to any input.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - the state enum (RUN=2'd0, MEM_WAIT=2'd1, MD_BUSY=2'd2);
  - MD_CNT_W=8 and WAIT_CNT_W=16;
  - default-control-vector constants.
- One natural sub-module: sat_counter (parameterised width, inc and clear inputs), instantiated for stall_cycles.

Test Plan:
- Reset mid-MD_BUSY (md_cnt=4) -> outputs immediately show forced reset values; after release, state RUN, all write enables=1, stall_cycles=0.
- load_use_hz=1 for one cycle in RUN -> pc_write=0, ifid_write=0, idex_bubble=1 for exactly 1 cycle; stall_cycles=1.
- dmem_req=1, dmem_ready=0 for 3 cycles then 1 -> freeze plus memwb_bubble=1 for 3 cycles, normal on the 4th; mem_timeout=0; stall_cycles=3.
- MEM_TIMEOUT=4, dmem_ready held 0 for 10 cycles -> mem_timeout rises after the 4th wait cycle and remains 1 after dmem_ready.
- md_start with MD_LATENCY=8 -> md_busy=1 and exmem_bubble=1 for 7 cycles; a memory wait of 2 cycles inside that window does not extend the total past 7.
- branch_taken=1 and load_use_hz=1 simultaneously -> ifid_flush=1, idex_bubble=1, pc_write=1; no stall cycle counted.
